msrh_rnid_freelist: RTL and testbench
=====================================

Name: msrh_rnid_freelist

Overview:
- Physical-register free list for the rename stage.
- Hands out new rd_rnid values to dispatch, one FIFO per dispatch lane.
- Consumes the commit-side rename update stream (cmt_rnid_upd_t) from the ROB and returns retired or dead RNIDs to the lane FIFO they belong to.
- Sits between the ROB commit port and the rename/dispatch stage. It is the receiving end of cmt_rnid_upd_t.

Parameters:
- DISP_SIZE, msrh_conf_pkg::DISP_SIZE (default 2), number of dispatch lanes and FIFOs.
- FLIST_SIZE, msrh_pkg::FLIST_SIZE (32), entries per lane FIFO.
- RNID_W, msrh_pkg::RNID_W, physical register ID width.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  reset.
- i_cmt_rnid_upd  in  cmt_rnid_upd_t  commit rename update from ROB.
- i_pop_valid  in  DISP_SIZE  per-lane request for a new RNID this cycle.
- o_pop_ready  out  DISP_SIZE  per-lane: an RNID is available (lane not empty).
- o_pop_rnid  out  DISP_SIZE x RNID_W  per-lane head RNID.
- o_count  out  DISP_SIZE x ($clog2(FLIST_SIZE)+1)  per-lane occupancy.

Interface rule (already decided): one clock, i_clk; reset i_reset_n is synchronous and active-low.

Behaviour:
- Storage per lane L:
  - FLIST_SIZE x RNID_W array.
  - head and tail pointers, $clog2(FLIST_SIZE) bits each, wrapping modulo FLIST_SIZE.
  - count register, 0..FLIST_SIZE.
- Reset (sampled at i_clk when i_reset_n=0, including mid-operation):
  - entry k of lane L = 32 + L*FLIST_SIZE + k.
  - head = 0, tail = 0, count = FLIST_SIZE.
  - All in-flight state is discarded.
  - Post-reset outputs: o_pop_ready = all 1, o_pop_rnid[L] = 32 + L*FLIST_SIZE, o_count[L] = FLIST_SIZE.
- Pop:
  - o_pop_ready[L] = (count[L] != 0).
  - o_pop_rnid[L] = array[L][head[L]], combinational from registers, zero latency.
  - A pop is granted when i_pop_valid[L] & o_pop_ready[L]. On the next edge head[L] increments and count[L] decrements.
  - i_pop_valid with ready=0 changes nothing; the requester must stall.
- Push, from commit:
  - Lane L pushes when i_cmt_rnid_upd.commit & rnid_valid[L].
  - The pushed value is chosen per lane:
    - dead_id[L] | all_dead → rd_rnid[L] (the speculative mapping is discarded).
    - otherwise → old_rnid[L] (the previous mapping retires).
  - The value is written at tail[L]; on the next edge tail increments and count increments.
  - except_valid / except_type do not affect push selection.
- Simultaneous push and pop on the same lane:
  - Both take effect and count is unchanged.
  - There is no bypass: when count=0, a push in the same cycle does not make the pop ready. The pushed value becomes visible next cycle.
- Full:
  - A push with count=FLIST_SIZE and no same-cycle pop is a protocol error.
  - A simulation assertion fires; the push is dropped and state is unchanged.
- Lane independence: lanes never exchange RNIDs. The ROB guarantees lane L's returns originate from lane L's pops.
- Flush recovery: speculative pops are recovered only through dead-instruction returns at commit. There is no pointer snapshot or restore in this block.
- Pointer arithmetic: pointers increment by 1 with natural modulo wrap. count uses a separate counter; pointers are never compared.

Decomposition:
- Shared package (msrh_pkg): cmt_rnid_upd_t, FLIST_SIZE, RNID_W, RNID_SIZE are already there.
- Sub-module msrh_freelist_fifo: single-lane FIFO with reset-initialised contents, parameter LANE_BASE, and push/pop/count.
  - Instantiated DISP_SIZE times with LANE_BASE = 32 + L*FLIST_SIZE.
- The top level holds only the push-value mux and the commit decode.

Test Plan:
- Reset with DISP_SIZE=2, then pop lane0 for 3 cycles → o_pop_rnid 32, 33, 34. Lane1 head = 64; o_count = {32, 29}.
- Pop lane0 32 times → o_pop_ready[0]=0, o_count[0]=0. A 33rd i_pop_valid[0] → no change; lane1 unaffected.
- Empty lane0, then commit=1, rnid_valid=01, dead_id=00, old_rnid[0]=5 → next cycle ready[0]=1, pop returns 5, count[0]=1.
- Commit=1, rnid_valid=11, dead_id=10, old_rnid={_,7}, rd_rnid={70,_} → lane0 receives 7, lane1 receives 70. all_dead=1 with rnid_valid=01, rd_rnid[0]=40 → lane0 receives 40.
- count[0]=1 with simultaneous pop and push of 9 → pops the old head, count stays 1, next head = 9. count[0]=0 with simultaneous push and pop → pop not granted, count becomes 1.
- Push to full lane0 → assertion fires, count stays 32. Then assert i_reset_n=0 mid-stream for one cycle → contents, pointers and counts return to reset values.

Source files
------------

// File: rtl/msrh_conf_pkg.sv
// msrh_conf_pkg: core-wide configuration knobs shared by rename/dispatch.
// Rev 1.0
`default_nettype none

package msrh_conf_pkg;
    localparam int DISP_SIZE = 2;
endpackage

`default_nettype wire

// File: rtl/msrh_pkg.sv
// msrh_pkg: rename-stage sizes and the ROB commit rename update record.
// Rev 1.0
`default_nettype none

package msrh_pkg;
    localparam int FLIST_SIZE = 32;
    // Architectural IDs occupy 0..31; each lane owns FLIST_SIZE physical IDs above that.
    localparam int RNID_SIZE  = 128;
    localparam int RNID_W     = $clog2(RNID_SIZE);

    typedef enum logic [1:0] {
        EXC_NONE   = 2'd0,
        EXC_BRANCH = 2'd1,
        EXC_TRAP   = 2'd2,
        EXC_FLUSH  = 2'd3
    } except_t;

    typedef struct packed {
        logic                                              commit;
        logic [msrh_conf_pkg::DISP_SIZE-1:0]               rnid_valid;
        logic [msrh_conf_pkg::DISP_SIZE-1:0][RNID_W-1:0]   old_rnid;
        logic [msrh_conf_pkg::DISP_SIZE-1:0][RNID_W-1:0]   rd_rnid;
        logic [msrh_conf_pkg::DISP_SIZE-1:0]               dead_id;
        logic                                              all_dead;
        logic                                              except_valid;
        except_t                                           except_type;
    } cmt_rnid_upd_t;
endpackage

`default_nettype wire

// File: rtl/msrh_freelist_fifo.sv
// msrh_freelist_fifo: single-lane RNID FIFO, reset-filled with LANE_BASE + k.
// Rev 1.0
`default_nettype none

module msrh_freelist_fifo #(
    parameter int FLIST_SIZE = 32,
    parameter int RNID_W     = 7,
    parameter int LANE_BASE  = 32
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic                            i_push,
    input  logic [RNID_W-1:0]               i_push_rnid,
    input  logic                            i_pop,
    output logic                            o_ready,
    output logic [RNID_W-1:0]               o_rnid,
    output logic [$clog2(FLIST_SIZE):0]     o_count
);
    localparam int PTR_W = $clog2(FLIST_SIZE);
    localparam int CNT_W = PTR_W + 1;

    logic [RNID_W-1:0] mem [FLIST_SIZE];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              pop_ok;
    logic              push_ok;

    assign full    = (count == CNT_W'(FLIST_SIZE));
    assign pop_ok  = i_pop & (count != '0);
    // A full lane may still accept a push when the same cycle pops a slot free.
    assign push_ok = i_push & (~full | pop_ok);

    assign o_ready = (count != '0);
    assign o_rnid  = mem[head];
    assign o_count = count;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int k = 0; k < FLIST_SIZE; k++) begin
                mem[k] <= RNID_W'(LANE_BASE + k);
            end
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(FLIST_SIZE);
        end else begin
            if (push_ok) begin
                mem[tail] <= i_push_rnid;
                tail      <= tail + PTR_W'(1);
            end
            if (pop_ok) begin
                head <= head + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset_n) begin
            assert (!(i_push && full && !pop_ok));
        end
    end

endmodule

`default_nettype wire

// File: rtl/msrh_rnid_freelist.sv
// msrh_rnid_freelist: per-lane physical register free lists fed by ROB commit.
// Rev 1.0
`default_nettype none

module msrh_rnid_freelist
    import msrh_pkg::cmt_rnid_upd_t;
#(
    parameter int DISP_SIZE  = msrh_conf_pkg::DISP_SIZE,
    parameter int FLIST_SIZE = msrh_pkg::FLIST_SIZE,
    parameter int RNID_W     = msrh_pkg::RNID_W
) (
    input  logic                                          i_clk,
    input  logic                                          i_reset_n,
    input  cmt_rnid_upd_t                                 i_cmt_rnid_upd,
    input  logic [DISP_SIZE-1:0]                          i_pop_valid,
    output logic [DISP_SIZE-1:0]                          o_pop_ready,
    output logic [DISP_SIZE-1:0][RNID_W-1:0]              o_pop_rnid,
    output logic [DISP_SIZE-1:0][$clog2(FLIST_SIZE):0]    o_count
);
    logic [DISP_SIZE-1:0]             push;
    logic [DISP_SIZE-1:0][RNID_W-1:0] push_rnid;

    // Exception information never influences which RNID is returned.
    logic unused_except;
    assign unused_except = ^{i_cmt_rnid_upd.except_valid, i_cmt_rnid_upd.except_type};

    generate
        for (genvar l = 0; l < DISP_SIZE; l++) begin : g_lane
            assign push[l] = i_cmt_rnid_upd.commit & i_cmt_rnid_upd.rnid_valid[l];
            // Dead instructions hand back their own speculative mapping; live ones retire the old one.
            assign push_rnid[l] = (i_cmt_rnid_upd.dead_id[l] | i_cmt_rnid_upd.all_dead)
                                ? i_cmt_rnid_upd.rd_rnid[l]
                                : i_cmt_rnid_upd.old_rnid[l];

            msrh_freelist_fifo #(
                .FLIST_SIZE (FLIST_SIZE),
                .RNID_W     (RNID_W),
                .LANE_BASE  (32 + l * FLIST_SIZE)
            ) u_fifo (
                .i_clk       (i_clk),
                .i_reset_n   (i_reset_n),
                .i_push      (push[l]),
                .i_push_rnid (push_rnid[l]),
                .i_pop       (i_pop_valid[l]),
                .o_ready     (o_pop_ready[l]),
                .o_rnid      (o_pop_rnid[l]),
                .o_count     (o_count[l])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_msrh_rnid_freelist.sv
// tb_msrh_rnid_freelist: directed vector bench for the rename free list.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_msrh_rnid_freelist;
    import msrh_pkg::*;

    localparam int DS = 2;
    localparam int FS = 32;
    localparam int RW = msrh_pkg::RNID_W;
    localparam int CW = $clog2(FS) + 1;

    logic                       clk = 1'b0;
    logic                       reset_n;
    cmt_rnid_upd_t              upd;
    logic [DS-1:0]              pop_valid;
    logic [DS-1:0]              pop_ready;
    logic [DS-1:0][RW-1:0]      pop_rnid;
    logic [DS-1:0][CW-1:0]      count;

    int n_cmp = 0;
    int n_err = 0;

    msrh_rnid_freelist dut (
        .i_clk          (clk),
        .i_reset_n      (reset_n),
        .i_cmt_rnid_upd (upd),
        .i_pop_valid    (pop_valid),
        .o_pop_ready    (pop_ready),
        .o_pop_rnid     (pop_rnid),
        .o_count        (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    pop;
        logic          commit;
        logic [1:0]    rv;
        logic [1:0]    dead;
        logic          all_dead;
        logic          exc;
        logic [RW-1:0] old0, old1, rd0, rd1;
        logic [1:0]    e_ready;
        logic [RW-1:0] e_rnid0, e_rnid1;
        logic [CW-1:0] e_cnt0, e_cnt1;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        pop_valid         = '0;
        upd               = '0;
        upd.except_type   = EXC_NONE;
    endtask

    task automatic push0(input logic [RW-1:0] v);
        upd.commit        = 1'b1;
        upd.rnid_valid    = 2'b01;
        upd.old_rnid[0]   = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".ready"}, int'(pop_ready), 3);
        chk({tag, ".rnid0"}, int'(pop_rnid[0]), 32);
        chk({tag, ".rnid1"}, int'(pop_rnid[1]), 64);
        chk({tag, ".cnt0"},  int'(count[0]), 32);
        chk({tag, ".cnt1"},  int'(count[1]), 32);
    endtask

    int exp_q[$];

    initial begin
        //          pop    cmt   rv     dead   ad    exc   old0 old1 rd0  rd1  ready  rn0  rn1  c0  c1
        vecs[0] = '{2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 0,   0,   0,   0,   2'b11, 33,  64,  31, 32};
        vecs[1] = '{2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 0,   0,   0,   0,   2'b11, 34,  64,  30, 32};
        vecs[2] = '{2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 0,   0,   0,   0,   2'b11, 35,  64,  29, 32};
        vecs[3] = '{2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 0,   0,   0,   0,   2'b11, 35,  65,  29, 31};
        // lane0 retires old 7, lane1 is dead and returns its rd 70
        vecs[4] = '{2'b00, 1'b1, 2'b11, 2'b10, 1'b0, 1'b0, 7,   99,  98,  70,  2'b11, 35,  65,  30, 32};
        // all_dead forces rd selection on lane0
        vecs[5] = '{2'b00, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 11,  0,   40,  0,   2'b11, 35,  65,  31, 32};
        // exception flag must not change the selection
        vecs[6] = '{2'b00, 1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 12,  0,   13,  0,   2'b11, 35,  65,  32, 32};
        // full lane0 with simultaneous pop and push of 14
        vecs[7] = '{2'b01, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 14,  0,   0,   0,   2'b11, 36,  65,  32, 32};

        idle();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        chk_reset("reset");

        foreach (vecs[i]) begin
            pop_valid           = vecs[i].pop;
            upd.commit          = vecs[i].commit;
            upd.rnid_valid      = vecs[i].rv;
            upd.dead_id         = vecs[i].dead;
            upd.all_dead        = vecs[i].all_dead;
            upd.except_valid    = vecs[i].exc;
            upd.except_type     = vecs[i].exc ? EXC_TRAP : EXC_NONE;
            upd.old_rnid[0]     = vecs[i].old0;
            upd.old_rnid[1]     = vecs[i].old1;
            upd.rd_rnid[0]      = vecs[i].rd0;
            upd.rd_rnid[1]      = vecs[i].rd1;
            tick();
            idle();
            chk($sformatf("v%0d.ready", i), int'(pop_ready),   int'(vecs[i].e_ready));
            chk($sformatf("v%0d.rnid0", i), int'(pop_rnid[0]), int'(vecs[i].e_rnid0));
            chk($sformatf("v%0d.rnid1", i), int'(pop_rnid[1]), int'(vecs[i].e_rnid1));
            chk($sformatf("v%0d.cnt0", i),  int'(count[0]),    int'(vecs[i].e_cnt0));
            chk($sformatf("v%0d.cnt1", i),  int'(count[1]),    int'(vecs[i].e_cnt1));
        end

        // Drain lane0: 36..63 then the returned 7, 40, 12, 14 in FIFO order.
        for (int v = 36; v <= 63; v++) exp_q.push_back(v);
        exp_q.push_back(7);
        exp_q.push_back(40);
        exp_q.push_back(12);
        exp_q.push_back(14);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("drain%0d.ready0", i), int'(pop_ready[0]), 1);
            chk($sformatf("drain%0d.rnid0", i),  int'(pop_rnid[0]),  exp_q[i]);
            pop_valid = 2'b01;
            tick();
            idle();
            chk($sformatf("drain%0d.cnt0", i), int'(count[0]), 31 - i);
        end
        chk("empty.ready0", int'(pop_ready[0]), 0);

        // Pop request on an empty lane is ignored; lane1 untouched.
        pop_valid = 2'b01;
        tick();
        idle();
        chk("stall.ready0", int'(pop_ready[0]), 0);
        chk("stall.cnt0",   int'(count[0]), 0);
        chk("stall.cnt1",   int'(count[1]), 32);
        chk("stall.rnid1",  int'(pop_rnid[1]), 65);

        // Empty lane: push 5 with pop; no bypass, pop not granted.
        pop_valid = 2'b01;
        push0(7'd5);
        tick();
        idle();
        chk("nobypass.ready0", int'(pop_ready[0]), 1);
        chk("nobypass.cnt0",   int'(count[0]), 1);
        chk("nobypass.rnid0",  int'(pop_rnid[0]), 5);

        // count=1: pop the 5 while pushing 9.
        pop_valid = 2'b01;
        push0(7'd9);
        tick();
        idle();
        chk("pushpop.cnt0",  int'(count[0]), 1);
        chk("pushpop.rnid0", int'(pop_rnid[0]), 9);
        chk("pushpop.ready", int'(pop_ready), 3);

        // Mid-stream reset with activity on both lanes.
        reset_n   = 1'b0;
        pop_valid = 2'b11;
        push0(7'd3);
        tick();
        idle();
        reset_n = 1'b1;
        chk_reset("midreset");

        // Contents refilled: lane0 pops 32..36 again.
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("refill%0d.rnid0", i), int'(pop_rnid[0]), 32 + i);
            pop_valid = 2'b01;
            tick();
            idle();
        end
        chk("refill.cnt0", int'(count[0]), 27);
        chk("refill.cnt1", int'(count[1]), 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
